sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 51 +++++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the synchronous FIFO slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Smallest r such that 2**r >= value; used for address and pointer widths.
    function automatic int fifo_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// Latency: read data appears on rd_dat one cycle after rd_vld is sampled.
// Backpressure: none; caller guarantees only legal reads/writes are presented.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int AW     = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_vld,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;
    logic [DATA_W-1:0] rd_dat_d;

    // Read register loads the addressed entry on a read, otherwise holds.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_vld) begin
            rd_dat_d = mem[rd_addr];
        end
    end

    // Storage array is deliberately left unreset; only the write port updates it.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read register clears on reset so data_out starts at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy/threshold flags and sticky errors.
// Latency: 1 cycle write-to-readable; 1 cycle read_e-to-data_out.
// Backpressure: writes rejected when full (unless a read frees a slot), reads when empty.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  AF_LEVEL = DEPTH - 2,
    parameter int  AE_LEVEL = 2,
    localparam int AW       = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_e,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_e,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    // Illegal parameter sets stop elaboration rather than building a broken FIFO.
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
        $fatal(1, "sync_fifo_param: DATA_W out of range 1..64");
    end
    if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two in 2..1024");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH-1");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_LEVEL out of range 1..DEPTH-1");
    end

    localparam logic [AW:0] AF_LVL  = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_LVL  = AE_LEVEL[AW:0];
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        rd_acc;
    logic        wr_acc;

    // Flags and count decode straight from the registered pointers.
    always_comb begin
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count        = wr_ptr_q - rd_ptr_q;
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
    end

    // Accept decisions, pointer advance and sticky error capture.
    always_comb begin
        rd_acc      = read_e && !empty;
        wr_acc      = write_e && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (write_e && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (read_e && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and error registers; reset wins over any concurrent operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Write/read enables are masked by reset so storage is untouched while held.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (wr_acc && reset),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_dat  (data_in),
        .rd_vld  (rd_acc && reset),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dat  (data_out)
    );

endmodule
